// File: rtl/mealy_dual_seq_det_if.sv
// -----------------------------------------------------------------------------
// mealy_dual_seq_det_if
// Bundle for the dual-pattern serial sequence detector.
//   master : drives the serial bit, its valid, and the configuration load
//   slave  : the detector; returns the Mealy flags y/z (and the match counters
//            when built with MATCH_CNT_EN)
// Signals
//   x, x_vld        serial bit and its qualifier
//   cfg_ld          load pat_a / pat_b / ovl_in this cycle
//   pat_a, pat_b    PAT_W-bit patterns, MSB = first bit received
//   ovl_in          overlap mode (1 = overlapping)
//   y, z            pattern A / pattern B completes with the current x
//   cnt_a, cnt_b    CNT_W-bit saturating match counters (MATCH_CNT_EN only)
// Optional feature macro: MATCH_CNT_EN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface mealy_dual_seq_det_if #(
    parameter int PAT_W = 4
`ifdef MATCH_CNT_EN
    , parameter int CNT_W = 8
`endif
);
    logic             x;
    logic             x_vld;
    logic             cfg_ld;
    logic [PAT_W-1:0] pat_a;
    logic [PAT_W-1:0] pat_b;
    logic             ovl_in;
    logic             y;
    logic             z;
`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    modport master (output x, x_vld, cfg_ld, pat_a, pat_b, ovl_in,
                    input  y, z, cnt_a, cnt_b);
    modport slave  (input  x, x_vld, cfg_ld, pat_a, pat_b, ovl_in,
                    output y, z, cnt_a, cnt_b);
`else
    modport master (output x, x_vld, cfg_ld, pat_a, pat_b, ovl_in,
                    input  y, z);
    modport slave  (input  x, x_vld, cfg_ld, pat_a, pat_b, ovl_in,
                    output y, z);
`endif
endinterface

// File: rtl/mealy_dual_seq_det.sv
// -----------------------------------------------------------------------------
// mealy_dual_seq_det
// Dual-pattern Mealy serial sequence detector. Watches the serial bit x and
// flags pattern A on y and pattern B on z in the same cycle as the final bit.
// Pattern values and overlap mode are loadable at run time.
// Ports
//   clk   in   single clock, all state updates on posedge
//   rst   in   synchronous active-high reset (priority over everything)
//   bus   slave modport of mealy_dual_seq_det_if (x, x_vld, cfg_ld, pat_a,
//         pat_b, ovl_in in; y, z and optional cnt_a/cnt_b out)
// Optional feature macro: MATCH_CNT_EN
//   defined   -> saturating per-pattern match counters cnt_a / cnt_b
//   undefined -> counters absent, behaviour otherwise identical
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mealy_dual_seq_det #(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] DEF_A = 4'b1011,
    parameter logic [PAT_W-1:0] DEF_B = 4'b0110,
    parameter logic           DEF_OVL = 1'b1
`ifdef MATCH_CNT_EN
    , parameter int           CNT_W   = 8
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    mealy_dual_seq_det_if.slave  bus
);

    localparam int FCNT_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(PAT_W - 1);
    localparam logic [FCNT_W-1:0] FCNT_PRE  = FCNT_W'(PAT_W - 2);

    // FILL: fewer than PAT_W-1 bits of history; ARMED: the next bit can match
    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    logic [0:0]       st_q,    st_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [PAT_W-2:0] hist_q,  hist_d;
    logic [PAT_W-1:0] pat_a_q, pat_a_d;
    logic [PAT_W-1:0] pat_b_q, pat_b_d;
    logic             ovl_q,   ovl_d;

    logic [PAT_W-1:0] win_s;
    logic             armed_s;
    logic             hit_a_s;
    logic             hit_b_s;

    // Mealy match: current bit appended to the stored history
    always_comb begin
        win_s   = {hist_q, bus.x};
        armed_s = (st_q == ST_ARMED);
        if (!rst && !bus.cfg_ld && bus.x_vld && armed_s) begin
            hit_a_s = (win_s == pat_a_q);
            hit_b_s = (win_s == pat_b_q);
        end else begin
            hit_a_s = 1'b0;
            hit_b_s = 1'b0;
        end
    end

    assign bus.y = hit_a_s;
    assign bus.z = hit_b_s;

    // Next-state: configuration load wins over an accepted bit
    always_comb begin
        st_d    = st_q;
        fcnt_d  = fcnt_q;
        hist_d  = hist_q;
        pat_a_d = pat_a_q;
        pat_b_d = pat_b_q;
        ovl_d   = ovl_q;
        if (bus.cfg_ld) begin
            pat_a_d = bus.pat_a;
            pat_b_d = bus.pat_b;
            ovl_d   = bus.ovl_in;
            hist_d  = {(PAT_W-1){1'b0}};
            fcnt_d  = {FCNT_W{1'b0}};
            st_d    = ST_FILL;
        end else if (bus.x_vld) begin
            // the window's low PAT_W-1 bits are the shifted history
            hist_d = win_s[PAT_W-2:0];
            case (st_q)
                ST_FILL: begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                    if (fcnt_q == FCNT_PRE) begin
                        st_d = ST_ARMED;
                    end else begin
                        st_d = ST_FILL;
                    end
                end
                ST_ARMED: begin
                    // non-overlapping: a hit discards history so the next
                    // match needs PAT_W fresh bits (one clear even if A==B)
                    if ((hit_a_s || hit_b_s) && !ovl_q) begin
                        hist_d = {(PAT_W-1){1'b0}};
                        fcnt_d = {FCNT_W{1'b0}};
                        st_d   = ST_FILL;
                    end else begin
                        fcnt_d = FCNT_LAST;
                        st_d   = ST_ARMED;
                    end
                end
                default: begin
                    hist_d = {(PAT_W-1){1'b0}};
                    fcnt_d = {FCNT_W{1'b0}};
                    st_d   = ST_FILL;
                end
            endcase
        end else begin
            st_d = st_q;
        end
    end

    // State registers with synchronous reset to the default configuration
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_FILL;
            fcnt_q  <= {FCNT_W{1'b0}};
            hist_q  <= {(PAT_W-1){1'b0}};
            pat_a_q <= DEF_A;
            pat_b_q <= DEF_B;
            ovl_q   <= DEF_OVL;
        end else begin
            st_q    <= st_d;
            fcnt_q  <= fcnt_d;
            hist_q  <= hist_d;
            pat_a_q <= pat_a_d;
            pat_b_q <= pat_b_d;
            ovl_q   <= ovl_d;
        end
    end

`ifdef MATCH_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    // Saturating match counters, cleared by a configuration load
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (bus.cfg_ld) begin
            cnt_a_d = {CNT_W{1'b0}};
            cnt_b_d = {CNT_W{1'b0}};
        end else begin
            if (hit_a_s && (cnt_a_q != CNT_MAX)) begin
                cnt_a_d = cnt_a_q + CNT_W'(1);
            end else begin
                cnt_a_d = cnt_a_q;
            end
            if (hit_b_s && (cnt_b_q != CNT_MAX)) begin
                cnt_b_d = cnt_b_q + CNT_W'(1);
            end else begin
                cnt_b_d = cnt_b_q;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a_q <= {CNT_W{1'b0}};
            cnt_b_q <= {CNT_W{1'b0}};
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign bus.cnt_a = cnt_a_q;
    assign bus.cnt_b = cnt_b_q;
`endif

endmodule
